// File: rtl/joypad_port_seq.sv
// NES joypad ports at $4016/$4017: strobe latch, per-player 8-bit shift registers
// and per-port read state machines, advanced only on qualified CPU bus cycles.
module joypad_port_seq #(
  parameter logic [7:0] OPEN_BUS = 8'h40,
  parameter logic       FILL_BIT = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_ce,
  input  logic [15:0] addr,
  input  logic        wren,
  input  logic [7:0]  din,
  input  logic [7:0]  pad0_btn,
  input  logic [7:0]  pad1_btn,
  output logic [7:0]  dout,
  output logic        dout_valid,
  output logic        strobe
);

  localparam logic [15:0] ADDR_PORT0 = 16'h4016;
  localparam logic [15:0] ADDR_PORT1 = 16'h4017;
  localparam logic [3:0]  CNT_FULL   = 4'd8;
  localparam int          NPORTS     = 2;

  typedef enum logic [1:0] {
    ST_LATCHED   = 2'd0,
    ST_READY     = 2'd1,
    ST_EXHAUSTED = 2'd2
  } port_state_e;

  // Registered state
  logic        r_strobe;
  logic [7:0]  r_dout;
  logic        r_dout_valid;
  port_state_e r_state [NPORTS];
  logic [7:0]  r_shreg [NPORTS];
  logic [3:0]  r_cnt   [NPORTS];

  // Next-state and decode wires
  logic        w_strobe_nxt;
  logic [7:0]  w_dout_nxt;
  logic        w_dout_valid_nxt;
  port_state_e w_state_nxt [NPORTS];
  logic [7:0]  w_shreg_nxt [NPORTS];
  logic [3:0]  w_cnt_nxt   [NPORTS];
  logic        w_bit       [NPORTS];
  logic [7:0]  w_pad       [NPORTS];
  logic        w_rd        [NPORTS];
  logic        w_wr_strobe;

  assign w_pad[0] = pad0_btn;
  assign w_pad[1] = pad1_btn;

  // Writes to $4017 belong to the APU frame counter, so only $4016 writes decode here.
  assign w_wr_strobe = cpu_ce &&  wren && (addr == ADDR_PORT0);
  assign w_rd[0]     = cpu_ce && !wren && (addr == ADDR_PORT0);
  assign w_rd[1]     = cpu_ce && !wren && (addr == ADDR_PORT1);

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    w_strobe_nxt     = r_strobe;
    w_dout_nxt       = r_dout;
    w_dout_valid_nxt = 1'b0;
    for (int p = 0; p < NPORTS; p++) begin
      w_state_nxt[p] = r_state[p];
      w_shreg_nxt[p] = r_shreg[p];
      w_cnt_nxt[p]   = r_cnt[p];
      w_bit[p]       = r_shreg[p][7];
    end

    if (w_wr_strobe) begin
      w_strobe_nxt = din[0];
      for (int p = 0; p < NPORTS; p++) begin
        w_cnt_nxt[p] = 4'd0;
        if (din[0]) begin
          w_shreg_nxt[p] = w_pad[p];
          w_state_nxt[p] = ST_LATCHED;
        end else begin
          // Falling strobe captures the buttons one last time before shifting starts.
          if (r_strobe) w_shreg_nxt[p] = w_pad[p];
          w_state_nxt[p] = ST_READY;
        end
      end
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (w_rd[p]) begin
          unique case (r_state[p])
            ST_LATCHED: begin
              w_bit[p]       = w_pad[p][7];
              w_shreg_nxt[p] = w_pad[p];
              w_cnt_nxt[p]   = 4'd0;
            end
            ST_READY: begin
              w_shreg_nxt[p] = {r_shreg[p][6:0], FILL_BIT};
              w_cnt_nxt[p]   = r_cnt[p] + 4'd1;
              if (r_cnt[p] == 4'd7) w_state_nxt[p] = ST_EXHAUSTED;
            end
            ST_EXHAUSTED: begin
              w_shreg_nxt[p] = {r_shreg[p][6:0], FILL_BIT};
              w_cnt_nxt[p]   = CNT_FULL;
            end
            default: begin
              w_state_nxt[p] = ST_EXHAUSTED;
              w_cnt_nxt[p]   = CNT_FULL;
            end
          endcase
        end
      end
    end

    // A single access per cpu_ce pulse, so at most one of these fires.
    if (w_rd[0]) begin
      w_dout_nxt       = {OPEN_BUS[7:1], w_bit[0]};
      w_dout_valid_nxt = 1'b1;
    end else if (w_rd[1]) begin
      w_dout_nxt       = {OPEN_BUS[7:1], w_bit[1]};
      w_dout_valid_nxt = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs; the shift registers are small enough that
  // resetting them explicitly costs nothing and gives a defined EXHAUSTED start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_strobe     <= 1'b0;
      r_dout       <= 8'h00;
      r_dout_valid <= 1'b0;
      for (int p = 0; p < NPORTS; p++) begin
        r_state[p] <= ST_EXHAUSTED;
        r_shreg[p] <= 8'hFF;
        r_cnt[p]   <= CNT_FULL;
      end
    end else begin
      r_strobe     <= w_strobe_nxt;
      r_dout       <= w_dout_nxt;
      r_dout_valid <= w_dout_valid_nxt;
      for (int p = 0; p < NPORTS; p++) begin
        r_state[p] <= w_state_nxt[p];
        r_shreg[p] <= w_shreg_nxt[p];
        r_cnt[p]   <= w_cnt_nxt[p];
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign strobe     = r_strobe;

endmodule
